ex_muldiv: RTL and testbench



---
 rtl/ex_muldiv_pkg.sv | 36 +++
 rtl/ex_muldiv_div_radix2.sv | 55 +++++
 rtl/ex_muldiv.sv | 223 ++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the ex_muldiv multiply/divide unit:
// operation codes, FSM state encoding and op-class helper functions.
package ex_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_MULH  = 3'd1,
        OP_MULHU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MOD   = 3'd5,
        OP_MODU  = 3'd6,
        OP_RSV   = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return (op == OP_MOD) || (op == OP_MODU);
    endfunction

endpackage

// File: rtl/ex_muldiv_div_radix2.sv
// Iterative restoring radix-2 divider on unsigned magnitudes.
// A start pulse loads the operands; one quotient bit is produced per cycle
// and done is high during the last iteration, so quotient/remainder hold
// the final values from the following cycle on.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    assign shifted = {remainder, quotient[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign done    = busy && (cnt == CW'(WIDTH - 1));

    // Shift-subtract iteration; a borrow in diff means the trial subtract is restored.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy      <= 1'b0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dvs       <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= '0;
            quotient  <= dividend;
            remainder <= '0;
            dvs       <= divisor;
        end else if (busy) begin
            remainder <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], ~diff[WIDTH]};
            cnt       <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit for the execution stage.
// One operation in flight, valid/ready on both sides, registered writeback.
// Optional feature macro: MULDIV_EARLY_OUT_EN lets trivial divides
// (divisor zero or |dividend| < |divisor|) finish one cycle after acceptance.
module ex_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] reg1_i,
    input  logic [DATA_WIDTH-1:0] reg2_i,
    input  logic [4:0]            wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           inst_pc_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [4:0]            wd_o,
    output logic                  wreg_o,
    output logic [31:0]           inst_pc_o,
    output logic                  busy_o
);

    import ex_muldiv_pkg::*;

    localparam int W   = DATA_WIDTH;
    localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    state_e           state;
    state_e           state_nxt;
    logic [2:0]       op_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [MCW-1:0]   mul_cnt;
    logic             accept;
    logic             valid_nxt;
    logic [W-1:0]     wdata_nxt;
    logic [2:0]       src_op;
    logic [W-1:0]     src_a;
    logic [W-1:0]     src_b;
    logic             neg_a;
    logic             neg_b;
    logic [W-1:0]     mag_a;
    logic [W-1:0]     mag_b;
    logic [2*W-1:0]   prod_mag;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     mul_res;
    logic             div_class;
    logic             div_start;
    logic             div_done;
    logic [W-1:0]     div_quo;
    logic [W-1:0]     div_rem;
    logic [W-1:0]     quo_fix;
    logic [W-1:0]     rem_fix;
    logic [W-1:0]     div_res;

    assign ready_o = (state == S_IDLE);
    assign busy_o  = (state != S_IDLE);
    assign accept  = valid_i && ready_o && !flush;

    // While idle the datapath looks at the request itself, otherwise at the latched copy.
    assign src_op = ready_o ? op_i   : op_q;
    assign src_a  = ready_o ? reg1_i : a_q;
    assign src_b  = ready_o ? reg2_i : b_q;

    assign neg_a = is_signed(src_op) && src_a[W-1];
    assign neg_b = is_signed(src_op) && src_b[W-1];
    assign mag_a = neg_a ? -src_a : src_a;
    assign mag_b = neg_b ? -src_b : src_b;

    assign prod_mag = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
    assign prod     = (neg_a ^ neg_b) ? -prod_mag : prod_mag;
    assign mul_res  = (src_op == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];

    // Divide-by-zero overrides the sign fix-up: all-ones quotient, dividend as remainder.
    assign quo_fix = (src_b == '0) ? {W{1'b1}} : ((neg_a ^ neg_b) ? -div_quo : div_quo);
    assign rem_fix = (src_b == '0) ? src_a : (neg_a ? -div_rem : div_rem);
    assign div_res = is_rem(src_op) ? rem_fix : quo_fix;

    assign div_class = !is_mul(op_i) && (op_i != OP_RSV);

`ifdef MULDIV_EARLY_OUT_EN
    logic         early_hit;
    logic [W-1:0] early_res;

    assign early_hit = (mag_b == '0) || (mag_a < mag_b);
    assign early_res = is_rem(src_op) ? src_a : ((mag_b == '0) ? {W{1'b1}} : {W{1'b0}});
    assign div_start = accept && div_class && !early_hit;
`else
    assign div_start = accept && div_class;
`endif

    div_radix2 #(
        .WIDTH(W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-result decode; flush overrides everything.
    always_comb begin
        state_nxt = state;
        wdata_nxt = wdata_o;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul(op_i)) begin
                        if (MUL_STAGES == 1) begin
                            state_nxt = S_DONE;
                            wdata_nxt = mul_res;
                        end else begin
                            state_nxt = S_MUL;
                        end
                    end else if (op_i == OP_RSV) begin
                        state_nxt = S_DONE;
                        wdata_nxt = '0;
                    end else begin
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_hit) begin
                            state_nxt = S_DONE;
                            wdata_nxt = early_res;
                        end else begin
                            state_nxt = S_DIV;
                        end
`else
                        state_nxt = S_DIV;
`endif
                    end
                end
            end
            S_MUL: begin
                if (mul_cnt == MCW'(MUL_STAGES - 2)) begin
                    state_nxt = S_DONE;
                    wdata_nxt = mul_res;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_DONE;
                wdata_nxt = div_res;
            end
            S_DONE: begin
                if (ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
        end
        valid_nxt = (state_nxt == S_DONE);
    end

    // Registered result and valid; held unchanged while waiting in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            wdata_o <= '0;
        end else begin
            valid_o <= valid_nxt;
            wdata_o <= wdata_nxt;
        end
    end

    // Capture the request operands and writeback tag on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wd_o      <= '0;
            wreg_o    <= 1'b0;
            inst_pc_o <= '0;
        end else if (accept) begin
            op_q      <= op_i;
            a_q       <= reg1_i;
            b_q       <= reg2_i;
            wd_o      <= wd_i;
            wreg_o    <= wreg_i;
            inst_pc_o <= inst_pc_i;
        end
    end

    // Cycles spent in MUL, restarting from zero whenever the state is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cnt <= '0;
        end else if (state == S_MUL) begin
            mul_cnt <= mul_cnt + MCW'(1);
        end else begin
            mul_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard testbench for ex_muldiv (DATA_WIDTH 32, MUL_STAGES 2).
// The driver issues requests and pushes reference results; the monitor
// compares whatever the DUT presents against the head of the queue.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] inst_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] inst_pc_o;
    logic        busy_o;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] pc;
        int          due;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int hold_left = 0;
    int flush_chk_cyc = -1;
    int stim_done_cyc = 0;
    bit stim_done = 0;
    bit stuck = 0;

    ex_muldiv #(
        .DATA_WIDTH(32),
        .MUL_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .reg1_i    (reg1_i),
        .reg2_i    (reg2_i),
        .wd_i      (wd_i),
        .wreg_i    (wreg_i),
        .inst_pc_i (inst_pc_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .wdata_o   (wdata_o),
        .wd_o      (wd_o),
        .wreg_o    (wreg_o),
        .inst_pc_o (inst_pc_o),
        .busy_o    (busy_o)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference result from plain signed/unsigned arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb2;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned ur;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        r   = 0;
        ur  = 0;
        case (op)
            3'd0: begin r = sa * sb2; return r[31:0]; end
            3'd1: begin r = sa * sb2; return r[63:32]; end
            3'd2: begin ur = ua * ub; return ur[63:32]; end
            3'd3: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                r = sa / sb2;
                return r[31:0];
            end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd5: begin
                if (b == 32'd0) return a;
                r = sa % sb2;
                return r[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                return a % b;
            end
            default: return 32'd0;
        endcase
    endfunction

    // Cycles from acceptance until the result is first presented.
    function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        bit          sgn;
        if (op <= 3'd2) return 2;
        if (op == 3'd7) return 1;
        sgn = (op == 3'd3) || (op == 3'd5);
        ma  = (sgn && a[31]) ? -a : a;
        mb  = (sgn && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
        if (b == 32'd0 || ma < mb) return 1;
`else
        if (ma == mb + 32'd1) return 34;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 4))
            0: return $urandom_range(0, 20);
            1: return 32'd0;
            2: case ($urandom_range(0, 3))
                   0: return 32'h8000_0000;
                   1: return 32'hFFFF_FFFF;
                   2: return 32'h7FFF_FFFF;
                   default: return 32'd1;
               endcase
            3: return -($urandom_range(1, 50));
            default: return $urandom;
        endcase
    endfunction

    // Advance one clock; ready_i is random except during a requested hold.
    task automatic tick();
        @(posedge clk);
        #1;
        if (hold_left > 0 && valid_o) begin
            ready_i   = 1'b0;
            hold_left = hold_left - 1;
        end else begin
            ready_i = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Present a request until accepted; optionally record its expected result.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit track, output int t_acc);
        exp_t e;
        int   waited;
        bit   got;
        t_acc = 0;
        if (stuck) return;
        op_i      = op;
        reg1_i    = a;
        reg2_i    = b;
        wd_i      = 5'($urandom);
        wreg_i    = 1'($urandom);
        inst_pc_i = $urandom & 32'hFFFF_FFFC;
        valid_i   = 1'b1;
        waited    = 0;
        got       = 0;
        while (!got && waited < 300) begin
            @(negedge clk);
            if (ready_o) begin
                got = 1;
            end else begin
                tick();
                waited++;
            end
        end
        if (!got) begin
            stuck   = 1;
            valid_i = 1'b0;
            return;
        end
        t_acc = cyc;
        if (track) begin
            e.data = model(op, a, b);
            e.wd   = wd_i;
            e.wreg = wreg_i;
            e.pc   = inst_pc_i;
            e.due  = cyc + latency(op, a, b);
            sb.push_back(e);
        end
        tick();
        valid_i = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: reset values, latency, result/tag, stability in DONE, turnaround, flush.
    bit          rst_q = 1'b1;
    bit          seen = 1'b0;
    bit          bubble = 1'b0;
    bit          stuck_seen = 1'b0;
    logic [31:0] held_data;
    logic [4:0]  held_wd;
    logic [31:0] held_pc;

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_valid_o", 64'(valid_o), 64'd0);
            checkOutput("rst_wdata_o", 64'(wdata_o), 64'd0);
            checkOutput("rst_wd_o", 64'(wd_o), 64'd0);
            checkOutput("rst_wreg_o", 64'(wreg_o), 64'd0);
            checkOutput("rst_inst_pc_o", 64'(inst_pc_o), 64'd0);
            checkOutput("rst_busy_o", 64'(busy_o), 64'd0);
        end else begin
            if (rst_q) begin
                checkOutput("ready_after_rst", 64'(ready_o), 64'd1);
            end
            if (bubble) begin
                checkOutput("turnaround_ready", 64'(ready_o), 64'd1);
                checkOutput("turnaround_valid", 64'(valid_o), 64'd0);
                bubble = 1'b0;
            end
            if (cyc == flush_chk_cyc) begin
                checkOutput("flush_ready", 64'(ready_o), 64'd1);
                checkOutput("flush_busy", 64'(busy_o), 64'd0);
            end
            if (valid_o) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_valid", 64'(valid_o), 64'd0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        checkOutput("latency", 64'(cyc), 64'(sb[0].due));
                        checkOutput("wdata", 64'(wdata_o), 64'(sb[0].data));
                        checkOutput("wd", 64'(wd_o), 64'(sb[0].wd));
                        checkOutput("wreg", 64'(wreg_o), 64'(sb[0].wreg));
                        checkOutput("inst_pc", 64'(inst_pc_o), 64'(sb[0].pc));
                        held_data = wdata_o;
                        held_wd   = wd_o;
                        held_pc   = inst_pc_o;
                    end else begin
                        checkOutput("hold_wdata", 64'(wdata_o), 64'(held_data));
                        checkOutput("hold_wd", 64'(wd_o), 64'(held_wd));
                        checkOutput("hold_inst_pc", 64'(inst_pc_o), 64'(held_pc));
                        checkOutput("hold_ready_o", 64'(ready_o), 64'd0);
                    end
                    if (ready_i) begin
                        void'(sb.pop_front());
                        seen   = 1'b0;
                        bubble = 1'b1;
                    end
                end
            end
            if (stuck && !stuck_seen) begin
                stuck_seen = 1'b1;
                n_vec++;
                n_bad++;
                $display("[TB] FAIL issue_timeout: ready_o never returned, expected acceptance");
            end
            if (stim_done && !bubble && (sb.size() == 0 || cyc > stim_done_cyc + 600)) begin
                if (sb.size() != 0) begin
                    n_vec++;
                    n_bad++;
                    $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
                $finish;
            end
        end
        rst_q = rst;
    end

    // Driver: reset, directed cases, ready_i hold, flush, then random traffic.
    initial begin
        int t;
        rst       = 1'b1;
        flush     = 1'b0;
        valid_i   = 1'b0;
        op_i      = 3'd0;
        reg1_i    = 32'd0;
        reg2_i    = 32'd0;
        wd_i      = 5'd0;
        wreg_i    = 1'b0;
        inst_pc_i = 32'd0;
        ready_i   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(3'd0, 32'hFFFF_FFFE, 32'd3, 1, t);
        applyStimulus(3'd1, 32'hFFFF_FFFE, 32'd3, 1, t);
        applyStimulus(3'd2, 32'hFFFF_FFFE, 32'd3, 1, t);
        applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2, 1, t);
        applyStimulus(3'd5, 32'hFFFF_FFF9, 32'd2, 1, t);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 1, t);
        applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1, t);
        applyStimulus(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1, t);
        applyStimulus(3'd4, 32'd5, 32'd0, 1, t);
        applyStimulus(3'd6, 32'd5, 32'd0, 1, t);
        applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd0, 1, t);
        applyStimulus(3'd7, 32'd123, 32'd45, 1, t);

        hold_left = 3;
        applyStimulus(3'd0, $urandom, $urandom, 1, t);
        applyStimulus(3'd1, $urandom, $urandom, 1, t);

        applyStimulus(3'd3, 32'd1000, 32'd3, 0, t);
        while (!stuck && cyc < t + 10) tick();
        flush_chk_cyc = t + 11;
        flush   = 1'b1;
        valid_i = 1'b1;
        op_i    = 3'd0;
        reg1_i  = 32'd9;
        reg2_i  = 32'd9;
        tick();
        flush   = 1'b0;
        valid_i = 1'b0;
        applyStimulus(3'd4, 32'd100, 32'd7, 1, t);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 1, t);
        end

        ready_i       = 1'b1;
        stim_done_cyc = cyc;
        stim_done     = 1'b1;
    end

endmodule
